// File: rtl/dma_arb_pkg.sv
// Shared types and helpers for the read-DMA descriptor arbiter.
package dma_arb_pkg;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

  localparam logic CH_X = 1'b0;
  localparam logic CH_W = 1'b1;

  localparam int DESC_ADDR_W = 32;
  localparam int DESC_LEN_W  = 32;
  localparam int DESC_USER_W = 65;

  typedef struct packed {
    logic [DESC_ADDR_W-1:0] addr;
    logic [DESC_LEN_W-1:0]  len;
    logic [DESC_USER_W-1:0] user;
  } desc_t;

  // Channel id is the tag MSB; tags up to 32 bits are passed zero-extended.
  function automatic logic tag_ch(input logic [31:0] tag, input int width);
    return 1'(tag >> (width - 1));
  endfunction

endpackage

// File: rtl/dma_arb_chan_track.sv
// Per-channel bookkeeping: sequence counter, outstanding count, sticky error,
// idle flag and the eligibility term used by the arbiter.
module dma_arb_chan_track #(
  parameter int SEQ_W           = 7,
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_W           = 3
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             src_valid,
  input  logic             in_slot,
  input  logic             load,
  input  logic             issue,
  input  logic             status,
  input  logic             status_err,
  input  logic             clr_err,
  output logic [SEQ_W-1:0] seq,
  output logic             eligible,
  output logic [CNT_W-1:0] outstanding,
  output logic             err,
  output logic             idle
);

  localparam logic [CNT_W:0] MAX_C = (CNT_W + 1)'(MAX_OUTSTANDING);

  logic [CNT_W:0] committed;
  logic           fault;

  // A descriptor parked in the output slot already counts against the cap.
  assign committed = {1'b0, outstanding} + {{CNT_W{1'b0}}, in_slot};
  assign eligible  = src_valid && (committed < MAX_C);
  assign fault     = status && !issue && (outstanding == '0);

  // NOTE: sequential state uses <= so every register samples pre-edge values;
  // blocking here would let later statements see already-updated state.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      seq         <= '0;
      outstanding <= '0;
      err         <= 1'b0;
      idle        <= 1'b1;
    end else begin
      if (load) seq <= seq + SEQ_W'(1);
      if (issue && !status) outstanding <= outstanding + CNT_W'(1);
      else if (status && !issue && !fault) outstanding <= outstanding - CNT_W'(1);
      err  <= (err && !clr_err) || (status && (status_err || fault));
      idle <= !src_valid && (outstanding == '0) && !in_slot;
    end
  end

endmodule

// File: rtl/dma_rd_arbiter.sv
// Round-robin arbiter sharing one read-DMA descriptor port between X and W.
// Define DMA_ARB_PERF_EN to add per-channel saturating wait-cycle counters.
module dma_rd_arbiter
  import dma_arb_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH  = 32,
  parameter int AXI_LEN_WIDTH   = 32,
  parameter int AXIS_USER_WIDTH = 65,
  parameter int AXI_TAG_WIDTH   = 8,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                    clk,
  input  logic                                    rstn,
  input  logic [AXI_ADDR_WIDTH-1:0]               s_xd_addr,
  input  logic [AXI_LEN_WIDTH-1:0]                s_xd_len,
  input  logic [AXIS_USER_WIDTH-1:0]              s_xd_user,
  input  logic                                    s_xd_valid,
  output logic                                    s_xd_ready,
  input  logic [AXI_ADDR_WIDTH-1:0]               s_wd_addr,
  input  logic [AXI_LEN_WIDTH-1:0]                s_wd_len,
  input  logic [AXIS_USER_WIDTH-1:0]              s_wd_user,
  input  logic                                    s_wd_valid,
  output logic                                    s_wd_ready,
  output logic [AXI_ADDR_WIDTH-1:0]               m_d_addr,
  output logic [AXI_LEN_WIDTH-1:0]                m_d_len,
  output logic [AXIS_USER_WIDTH-1:0]              m_d_user,
  output logic [AXI_TAG_WIDTH-1:0]                m_d_tag,
  output logic                                    m_d_valid,
  input  logic                                    m_d_ready,
  input  logic [AXI_TAG_WIDTH-1:0]                s_st_tag,
  input  logic [3:0]                              s_st_error,
  input  logic                                    s_st_valid,
  input  logic                                    clr_err,
  output logic                                    x_idle,
  output logic                                    w_idle,
  output logic                                    x_err,
  output logic                                    w_err,
`ifdef DMA_ARB_PERF_EN
  output logic [31:0]                             x_wait_cycles,
  output logic [31:0]                             w_wait_cycles,
`endif
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]    x_outstanding,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]    w_outstanding
);

  localparam int SEQ_W = AXI_TAG_WIDTH - 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  slot_state_t state;
  logic        rr_last;
  logic        slot_ch, st_ch, st_err;
  logic        loadable, handshake, grant_x, grant_w;
  logic        x_elig, w_elig;
  logic [SEQ_W-1:0] x_seq, w_seq;

  assign m_d_valid  = (state == SLOT_FULL);
  assign handshake  = m_d_valid && m_d_ready;
  assign loadable   = (state == SLOT_EMPTY) || m_d_ready;
  assign slot_ch    = m_d_tag[AXI_TAG_WIDTH-1];
  assign st_ch      = tag_ch(32'(s_st_tag), AXI_TAG_WIDTH);
  assign st_err     = |s_st_error;
  assign s_xd_ready = grant_x;
  assign s_wd_ready = grant_w;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    grant_x = 1'b0;
    grant_w = 1'b0;
    if (loadable) begin
      if (x_elig && w_elig) begin
        if (rr_last == CH_W) grant_x = 1'b1;
        else                 grant_w = 1'b1;
      end else begin
        grant_x = x_elig;
        grant_w = w_elig;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= SLOT_EMPTY;
      rr_last  <= CH_W;
      m_d_addr <= '0;
      m_d_len  <= '0;
      m_d_user <= '0;
      m_d_tag  <= '0;
    end else if (grant_x || grant_w) begin
      state    <= SLOT_FULL;
      rr_last  <= grant_w ? CH_W : CH_X;
      m_d_addr <= grant_w ? s_wd_addr : s_xd_addr;
      m_d_len  <= grant_w ? s_wd_len  : s_xd_len;
      m_d_user <= grant_w ? s_wd_user : s_xd_user;
      m_d_tag  <= grant_w ? {CH_W, w_seq} : {CH_X, x_seq};
    end else if (handshake) begin
      state <= SLOT_EMPTY;
    end
  end

  dma_arb_chan_track #(
    .SEQ_W(SEQ_W), .MAX_OUTSTANDING(MAX_OUTSTANDING), .CNT_W(CNT_W)
  ) u_x_track (
    .clk        (clk),
    .rstn       (rstn),
    .src_valid  (s_xd_valid),
    .in_slot    (m_d_valid && slot_ch == CH_X),
    .load       (grant_x),
    .issue      (handshake && slot_ch == CH_X),
    .status     (s_st_valid && st_ch == CH_X),
    .status_err (st_err),
    .clr_err    (clr_err),
    .seq        (x_seq),
    .eligible   (x_elig),
    .outstanding(x_outstanding),
    .err        (x_err),
    .idle       (x_idle)
  );

  dma_arb_chan_track #(
    .SEQ_W(SEQ_W), .MAX_OUTSTANDING(MAX_OUTSTANDING), .CNT_W(CNT_W)
  ) u_w_track (
    .clk        (clk),
    .rstn       (rstn),
    .src_valid  (s_wd_valid),
    .in_slot    (m_d_valid && slot_ch == CH_W),
    .load       (grant_w),
    .issue      (handshake && slot_ch == CH_W),
    .status     (s_st_valid && st_ch == CH_W),
    .status_err (st_err),
    .clr_err    (clr_err),
    .seq        (w_seq),
    .eligible   (w_elig),
    .outstanding(w_outstanding),
    .err        (w_err),
    .idle       (w_idle)
  );

`ifdef DMA_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (!rstn || clr_err) begin
      x_wait_cycles <= '0;
      w_wait_cycles <= '0;
    end else begin
      if (s_xd_valid && !grant_x && x_wait_cycles != '1) x_wait_cycles <= x_wait_cycles + 32'd1;
      if (s_wd_valid && !grant_w && w_wait_cycles != '1) w_wait_cycles <= w_wait_cycles + 32'd1;
    end
  end
`endif

endmodule
